// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the FP datapath.
// Used by the iterative divider and its mantissa core.
package fp32_pkg;

  localparam int FP32_BIAS = 127;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int QBITS = 26;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp32_mant_div.sv
// Restoring significand divider, one quotient bit per cycle.
// Loads on start, pulses done during its last iteration.
module fp32_mant_div
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      op_a,
  input  logic [23:0]      op_b,
  output logic             done,
  output logic [QBITS-1:0] q,
  output logic             rem_nz
);

  logic [25:0] r_q, r_d;
  logic [25:0] q_q, q_d;
  logic [23:0] b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        ge;
  logic [25:0] diff;

  // Trial subtract, shift and count down while running.
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    run_d = run_q;
    ge    = r_q >= {2'b00, b_q};
    diff  = ge ? r_q - {2'b00, b_q} : r_q;
    if (start) begin
      r_d   = {2'b00, op_a};
      b_d   = op_b;
      q_d   = '0;
      cnt_d = 5'(QBITS - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      r_d = {diff[24:0], 1'b0};
      q_d = {q_q[24:0], ge};
      if (cnt_q == 5'd0) run_d = 1'b0;
      else cnt_d = cnt_q - 5'd1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done   = run_q & (cnt_q == 5'd0);
  assign q      = q_q;
  assign rem_nz = |r_q;

endmodule

// File: rtl/fp32_divider_seq.sv
// Iterative FP32 divider with valid/ready handshake.
// FP32_DIV_RNE_EN selects round-to-nearest-even.
module fp32_divider_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  div_state_t state_q, state_d;
  logic       sign_q, sign_d;
  logic [7:0] ea_q, ea_d, eb_q, eb_d;
  logic [31:0] res_q, res_d;
  logic exc_q, exc_d, ovf_q, ovf_d;
  logic unf_q, unf_d, dbz_q, dbz_d;

  fp32_t fa, fb;
  logic  a_inf, b_inf, a_zero, b_zero;
  logic  op_sign;
  logic  div_start, div_done, rem_nz;
  logic [QBITS-1:0] div_q;

  logic [25:0] qn;
  logic signed [9:0] e_raw, e_fin;
  logic [23:0] mant_sum;
  logic guard, sticky, rnd;

  assign fa      = a;
  assign fb      = b;
  assign a_inf   = fa.exp == FP32_EXP_MAX;
  assign b_inf   = fb.exp == FP32_EXP_MAX;
  assign a_zero  = fa.exp == 8'd0;
  assign b_zero  = fb.exp == 8'd0;
  assign op_sign = fa.sign ^ fb.sign;

  fp32_mant_div u_mdiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (div_start),
    .op_a   ({1'b1, fa.mant}),
    .op_b   ({1'b1, fb.mant}),
    .done   (div_done),
    .q      (div_q),
    .rem_nz (rem_nz)
  );

  // Normalise the quotient, round and rebuild the exponent.
  always_comb begin
    qn     = div_q[25] ? div_q : {div_q[24:0], 1'b0};
    e_raw  = $signed({2'b00, ea_q})
           - $signed({2'b00, eb_q})
           + 10'(FP32_BIAS)
           - $signed({9'd0, ~div_q[25]});
    guard  = qn[1];
    sticky = qn[0] | rem_nz;
`ifdef FP32_DIV_RNE_EN
    rnd    = guard & (sticky | qn[2]);
`else
    rnd    = guard & sticky;
`endif
    mant_sum = {1'b0, qn[24:2]} + {23'd0, rnd};
    e_fin    = e_raw + $signed({9'd0, mant_sum[23]});
  end

  // Handshake FSM, special-case decode and result packing.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    res_d     = res_q;
    exc_d     = exc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = op_sign;
          ea_d    = fa.exp;
          eb_d    = fb.exp;
          exc_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = DONE;
          if (a_inf | b_inf) begin
            res_d = 32'h0;
            exc_d = 1'b1;
          end else if (b_zero) begin
            res_d = {op_sign, FP32_EXP_MAX, 23'd0};
            dbz_d = 1'b1;
          end else if (a_zero) begin
            res_d = {op_sign, 31'd0};
          end else begin
            div_start = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (div_done) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
        unique case (1'b1)
          (e_fin >= 10'sd255): begin
            ovf_d = 1'b1;
            res_d = {sign_q, FP32_EXP_MAX, 23'd0};
          end
          (e_fin <= 10'sd0): begin
            unf_d = 1'b1;
            res_d = {sign_q, 31'd0};
          end
          default: begin
            res_d = {sign_q, e_fin[7:0], mant_sum[22:0]};
          end
        endcase
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = rst_n & (state_q == IDLE);
  assign out_valid   = state_q == DONE;
  assign res         = res_q;
  assign exception   = exc_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// Directed bench for fp32_divider_seq.
// Hand-computed vectors, handshake, hold and reset cases.
module tb_fp32_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        exception, overflow, underflow, div_by_zero;

  int tests = 0;
  int fails = 0;

  fp32_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .exception   (exception),
    .overflow    (overflow),
    .underflow   (underflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flags();
    return {28'd0, exception, overflow, underflow, div_by_zero};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands, wait for accept; returns after accept edge + #1.
  task automatic accept(input logic [31:0] ta, input logic [31:0] tb);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges from accept (inclusive) until out_valid is seen.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [31:0] ta,
                       input logic [31:0] tb,
                       input logic [31:0] eres,
                       input logic [31:0] eflg,
                       input int elat);
    int n;
    accept(ta, tb);
    wait_out(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_res"}, res, eres);
    chk({tag, "_flg"}, flags(), eflg);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ack"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_flg", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ir", {31'd0, in_ready}, 32'd1);

    // flag order: exception, overflow, underflow, div_by_zero
    do_op("six_two", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h0, 28);
    do_op("one_thr", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h0, 28);
    do_op("m8_half", 32'hC1000000, 32'h3F000000, 32'hC1800000, 32'h0, 28);
    do_op("dbz", 32'h3F800000, 32'h00000000, 32'h7F800000, 32'h1, 1);
    do_op("exc", 32'h7F800000, 32'h3F800000, 32'h00000000, 32'h8, 1);
    do_op("zero", 32'h00000000, 32'hC0000000, 32'h80000000, 32'h0, 1);
    do_op("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 32'h4, 28);
    do_op("unf", 32'h00800000, 32'h7F000000, 32'h00000000, 32'h2, 28);

    // Hold result with out_ready low, new operands waiting.
    accept(32'h40C00000, 32'h40000000);
    wait_out(n);
    chk("hold_lat", n, 28);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_res", res, 32'h40400000);
      chk("hold_flg", flags(), 32'h0);
      chk("hold_ov", {31'd0, out_valid}, 32'd1);
      chk("hold_ir", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rel_ov", {31'd0, out_valid}, 32'd0);
    chk("rel_ir", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("acc_ir", {31'd0, in_ready}, 32'd0);
    wait_out(n);
    chk("acc_lat", n, 28);
    chk("acc_res", res, 32'h3EAAAAAB);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of CALC.
    accept(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_res", res, 32'd0);
    chk("mid_flg", flags(), 32'd0);
    chk("mid_ir", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_ir", {31'd0, in_ready}, 32'd1);
    do_op("post", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h0, 28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp32_divider_seq.md
Name: fp32_divider_seq

Overview:
- Iterative IEEE-754 single-precision divider, res = a / b; inverse operation of the team's FP32 multiplier, with matching flag semantics.
- Restoring mantissa division, one quotient bit per cycle.
- valid/ready handshake on input and output; sits beside the multiplier in the FP datapath.

Parameters:
- QBITS, 26, quotient bits generated (24 significand + guard + 1 normalisation bit); fixed, not for override.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  high only in IDLE
- a  input  32  dividend, FP32
- b  input  32  divisor, FP32
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- res  output  32  quotient, FP32
- exception  output  1  a or b has exponent 8'hFF
- overflow  output  1  result exponent >= 255
- underflow  output  1  result exponent <= 0
- div_by_zero  output  1  b is zero and a is finite

Behaviour:
- Reset (async, any state incl. mid-CALC): state=IDLE; out_valid, res and all flags = 0; in_ready=1 after reset release.
- States:
  - IDLE: in_ready=1. On in_valid: latch the operands and sign = a[31]^b[31]. Special operand -> DONE. Otherwise -> CALC, with remainder R = {2'b0, op_a}, cnt = 25.
  - CALC: each cycle, if R >= op_b then qbit=1 and R -= op_b, else qbit=0. Then R <<= 1 and q = {q[24:0], qbit}. At cnt==0 -> ROUND, else cnt--.
  - ROUND: normalise, round, pack, and set flags -> DONE.
  - DONE: out_valid=1. res and flags are stable while out_ready is low. When out_ready is high -> IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Operand decode:
  - op = {1, mant} when exponent != 0.
  - An operand with exponent 0 is treated as zero, whatever its mantissa (denormals flushed).
- Special priority: exception, then div_by_zero, then a==0.
  - exception: res = 32'h0, exception=1.
  - div_by_zero: res = {sign, 8'hFF, 23'd0}, div_by_zero=1.
  - a==0: res = {sign, 31'd0}, all flags 0.
  - All special cases: out_valid 1 cycle after accept.
- Normalisation:
  - If q[25]=1, use qn = q[25:0] and exponent adjust adj = 0.
  - Otherwise qn = q << 1 and adj = -1.
- Exponent: 10-bit signed, e = ea - eb + 127 + adj.
- Rounding:
  - guard = qn[1]; sticky = qn[0] | (R != 0).
  - Round up iff guard & sticky (ties round down).
  - mant = qn[24:2] + round. On mantissa carry-out, mant = 0 and e += 1.
- Result:
  - e >= 255: overflow=1, res = {sign, 8'hFF, 23'd0}.
  - e <= 0: underflow=1, res = {sign, 31'd0}.
  - Otherwise res = {sign, e[7:0], mant}.
- Latency for normal operands: accept edge, 26 CALC edges, 1 ROUND edge; out_valid is high 28 cycles after the accept edge.
- Flags are meaningful only while out_valid=1; at most one flag is set per result.

Optional Feature:
- FP32_DIV_RNE_EN defined: round to nearest even, i.e. round = guard & (sticky | qn[2]).
- Undefined: round = guard & sticky, matching the multiplier's rounding.

Decomposition:
- Package fp32_pkg holds:
  - FP32_BIAS = 127, FP32_EXP_MAX = 8'hFF, field widths (1/8/23).
  - fp32_t packed struct {sign, exp, mant}.
  - State enum {IDLE, CALC, ROUND, DONE}.
- Sub-module fp32_mant_div holds the restoring divider: R/q registers, 5-bit counter, start/done pulses.
- Top level owns decode, FSM, round/pack and the handshake.

Test Plan:
- 40C00000 / 40000000 (6/2) -> res 40400000, no flags, out_valid exactly 28 cycles after accept.
- 3F800000 / 40400000 (1/3) -> res 3EAAAAAB (rounds up in both modes); C1000000 / 3F000000 (-8/0.5) -> res C1800000.
- Specials:
  - 3F800000 / 00000000 -> 7F800000, div_by_zero=1.
  - 7F800000 / 3F800000 -> 00000000, exception=1.
  - 00000000 / C0000000 -> 80000000, no flags.
  - Each specials result has out_valid 1 cycle after accept.
- 7F000000 / 00800000 -> overflow=1, res 7F800000; 00800000 / 7F000000 -> underflow=1, res 00000000.
- Hold out_ready low for 5 cycles in DONE -> res and flags constant, in_ready=0; with in_valid held high, no new operand is accepted until 1 cycle after out_ready.
- Assert rst_n low at CALC cycle 10 -> all outputs 0 immediately; after release, 40C00000 / 40000000 completes normally to 40400000.
